// File: rtl/aes_key_expand_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key-schedule block.
package aes_key_expand_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    localparam int NUM_ROUNDS = 10;
    localparam int WORD_W     = 32;
    localparam int KEY_W      = 128;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Multiply in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_key_expand_sbox.sv
// Combinational AES S-box: field inverse followed by the affine transform.
module aes_sbox
    import aes_key_expand_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/rom_rc.sv
// Round-constant ROM: addresses 1..10 hold the AES rcon bytes, all others read zero.
module rom_rc #(
    parameter int width_p      = 8,
    parameter int addr_width_p = 4
) (
    input  logic [addr_width_p-1:0] addr_i,
    output logic [width_p-1:0]      data_o
);

    logic [7:0] w_byte;

    // Constant lookup table.
    always_comb begin
        w_byte = 8'h00;
        case (addr_i)
            addr_width_p'(1):  w_byte = 8'h01;
            addr_width_p'(2):  w_byte = 8'h02;
            addr_width_p'(3):  w_byte = 8'h04;
            addr_width_p'(4):  w_byte = 8'h08;
            addr_width_p'(5):  w_byte = 8'h10;
            addr_width_p'(6):  w_byte = 8'h20;
            addr_width_p'(7):  w_byte = 8'h40;
            addr_width_p'(8):  w_byte = 8'h80;
            addr_width_p'(9):  w_byte = 8'h1b;
            addr_width_p'(10): w_byte = 8'h36;
            default:           w_byte = 8'h00;
        endcase
    end

    assign data_o = width_p'(w_byte);

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits round keys 0..10 one per consumer handshake.
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int key_width_p     = 128,
    parameter int rc_addr_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [key_width_p-1:0] key_i,
    input  logic                   key_v_i,
    output logic                   key_ready_o,
    output logic [key_width_p-1:0] round_key_o,
    output logic [3:0]             round_idx_o,
    output logic                   v_o,
    input  logic                   yumi_i
);

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic [KEY_W-1:0]           r_round_key;
    logic [3:0]                 r_round;
    logic                       w_load;
    logic                       w_adv;
    logic [rc_addr_width_p-1:0] w_rc_addr;
    logic [7:0]                 w_rc;
    logic [WORD_W-1:0]          w_rot;
    logic [WORD_W-1:0]          w_sub;
    logic [WORD_W-1:0]          w_temp;
    logic [WORD_W-1:0]          w_w0;
    logic [WORD_W-1:0]          w_w1;
    logic [WORD_W-1:0]          w_w2;
    logic [WORD_W-1:0]          w_w3;

    assign w_rc_addr = rc_addr_width_p'(r_round + 4'd1);

    rom_rc #(
        .width_p      (8),
        .addr_width_p (rc_addr_width_p)
    ) u_rom_rc (
        .addr_i (w_rc_addr),
        .data_o (w_rc)
    );

    assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_temp = w_sub ^ {w_rc, 24'h000000};
    assign w_w0   = r_round_key[127:96] ^ w_temp;
    assign w_w1   = r_round_key[95:64]  ^ w_w0;
    assign w_w2   = r_round_key[63:32]  ^ w_w1;
    assign w_w3   = r_round_key[31:0]   ^ w_w2;

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (key_v_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EXPAND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (yumi_i && (r_round == LAST_ROUND)) begin
                    w_state_nxt = ST_IDLE;
                end else if (yumi_i) begin
                    w_adv = 1'b1;
                end else begin
                    w_state_nxt = ST_EXPAND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, round counter and round-key registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_round     <= 4'd0;
            r_round_key <= {KEY_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_round     <= 4'd0;
                r_round_key <= key_i;
            end else if (w_adv) begin
                r_round     <= r_round + 4'd1;
                r_round_key <= {w_w0, w_w1, w_w2, w_w3};
            end
        end
    end

    assign key_ready_o = (r_state == ST_IDLE);
    assign v_o         = (r_state == ST_EXPAND);
    assign round_key_o = r_round_key;
    assign round_idx_o = r_round;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a word-array FIPS-197 key-schedule model.
module tb_aes_key_expand;

    logic         clk_i;
    logic         reset_n_i;
    logic [127:0] key_i;
    logic         key_v_i;
    logic         key_ready_o;
    logic [127:0] round_key_o;
    logic [3:0]   round_idx_o;
    logic         v_o;
    logic         yumi_i;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_tbl [0:255];
    logic [127:0] exp_rk   [0:10];
    logic [127:0] got_rk   [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expand #(
        .key_width_p     (128),
        .rc_addr_width_p (4)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .key_i       (key_i),
        .key_v_i     (key_v_i),
        .key_ready_o (key_ready_o),
        .round_key_o (round_key_o),
        .round_idx_o (round_idx_o),
        .v_o         (v_o),
        .yumi_i      (yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int ref_mul(input int a, input int b);
        int p;
        int x;
        int y;
        p = 0;
        x = a;
        y = b;
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 283;
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (ref_mul(a, b) == 1) inv = 8'(b);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sbox_tbl[a] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc   = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = 8'(ref_mul(int'(rc), 2));
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Run one full schedule; caller is at posedge+1. With preloaded set, key_v_i is already driven.
    task automatic run_schedule(input logic [127:0] key, input int stall_pct, input bit preloaded,
                                input bit chain, input logic [127:0] next_key, input bit intrude,
                                input string name);
        int idx;
        int cycles;
        bit yumi;
        model_expand(key);
        if (!preloaded) begin
            total++;
            if (key_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL %s ready_before_load got=%b want=1", name, key_ready_o);
            end
            key_i   = key;
            key_v_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        key_v_i = 1'b0;
        key_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
        idx     = 0;
        cycles  = 0;
        while (idx <= 10 && cycles < 400) begin
            total++;
            if (v_o !== 1'b1 || key_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL %s handshake idx=%0d got v=%b ready=%b want v=1 ready=0",
                         name, idx, v_o, key_ready_o);
            end
            total++;
            if (round_idx_o !== 4'(idx)) begin
                bad++;
                $display("FAIL %s round_idx got=%0d want=%0d", name, round_idx_o, idx);
            end
            total++;
            if (round_key_o !== exp_rk[idx]) begin
                bad++;
                $display("FAIL %s round_key[%0d] got=%h want=%h", name, idx, round_key_o, exp_rk[idx]);
            end
            got_rk[idx] = round_key_o;
            if (intrude && idx >= 3 && idx <= 7) begin
                key_v_i = 1'b1;
                key_i   = ~key ^ {$urandom(), $urandom(), $urandom(), 32'h0000_0001};
            end else begin
                key_v_i = 1'b0;
            end
            yumi   = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            yumi_i = yumi;
            @(posedge clk_i);
            #1;
            cycles++;
            if (yumi) idx++;
        end
        yumi_i  = 1'b0;
        key_v_i = 1'b0;
        total++;
        if (cycles >= 400) begin
            bad++;
            $display("FAIL %s timeout got_rounds=%0d want=11", name, idx);
        end
        if (stall_pct == 0) begin
            total++;
            if (cycles != 11) begin
                bad++;
                $display("FAIL %s throughput got_cycles=%0d want=11", name, cycles);
            end
        end
        total++;
        if (v_o !== 1'b0 || key_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s after_last got v=%b ready=%b want v=0 ready=1", name, v_o, key_ready_o);
        end
        if (chain) begin
            key_i   = next_key;
            key_v_i = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        key_v_i   = 1'b0;
        yumi_i    = 1'b0;
        key_i     = 128'h0;
        repeat (3) @(posedge clk_i);
        #1;
        total++;
        if (v_o !== 1'b0 || key_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_handshake got v=%b ready=%b want v=0 ready=1", v_o, key_ready_o);
        end
        total++;
        if (round_idx_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_idx got=%0d want=0", round_idx_o);
        end
        total++;
        if (round_key_o !== 128'h0) begin
            bad++;
            $display("FAIL reset_key got=%h want=0", round_key_o);
        end
        reset_n_i = 1'b1;
    endtask

    task automatic test_idle_yumi();
        yumi_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        yumi_i = 1'b0;
        total++;
        if (v_o !== 1'b0 || key_ready_o !== 1'b1 || round_idx_o !== 4'd0) begin
            bad++;
            $display("FAIL idle_yumi got v=%b ready=%b idx=%0d want v=0 ready=1 idx=0",
                     v_o, key_ready_o, round_idx_o);
        end
    endtask

    task automatic test_known(input logic [127:0] key, input logic [127:0] r1, input logic [127:0] r10,
                              input int stall_pct, input string name);
        run_schedule(key, stall_pct, 1'b0, 1'b0, 128'h0, 1'b0, name);
        total++;
        if (got_rk[0] !== key || got_rk[1] !== r1 || got_rk[10] !== r10) begin
            bad++;
            $display("FAIL %s known_answer got r0=%h r1=%h r10=%h want r0=%h r1=%h r10=%h",
                     name, got_rk[0], got_rk[1], got_rk[10], key, r1, r10);
        end
    endtask

    task automatic test_random_stall();
        for (int n = 0; n < 3; n++) begin
            run_schedule({$urandom(), $urandom(), $urandom(), $urandom()}, 50, 1'b0, 1'b0,
                         128'h0, 1'b0, "random_stall");
        end
        test_known(FIPS_KEY, FIPS_R1, FIPS_R10, 50, "fips_stall");
    endtask

    task automatic test_intrusion();
        run_schedule({$urandom(), $urandom(), $urandom(), $urandom()}, 30, 1'b0, 1'b0,
                     128'h0, 1'b1, "intrusion");
    endtask

    task automatic test_reset_mid();
        int cycles;
        key_i   = FIPS_KEY;
        key_v_i = 1'b1;
        @(posedge clk_i);
        #1;
        key_v_i = 1'b0;
        cycles  = 0;
        while (round_idx_o != 4'd5 && cycles < 20) begin
            yumi_i = 1'b1;
            @(posedge clk_i);
            #1;
            cycles++;
        end
        yumi_i = 1'b0;
        total++;
        if (round_idx_o !== 4'd5 || v_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_reach got idx=%0d v=%b want idx=5 v=1", round_idx_o, v_o);
        end
        #2;
        reset_n_i = 1'b0;
        #1;
        total++;
        if (v_o !== 1'b0 || key_ready_o !== 1'b1 || round_idx_o !== 4'd0 || round_key_o !== 128'h0) begin
            bad++;
            $display("FAIL reset_mid_async got v=%b ready=%b idx=%0d key=%h want v=0 ready=1 idx=0 key=0",
                     v_o, key_ready_o, round_idx_o, round_key_o);
        end
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        run_schedule({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b0, 1'b0,
                     128'h0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1;
        logic [127:0] k2;
        k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_schedule(k1, 0, 1'b0, 1'b1, k2, 1'b0, "b2b_first");
        run_schedule(k2, 0, 1'b1, 1'b0, 128'h0, 1'b0, "b2b_second");
    endtask

    initial begin
        build_sbox();
        test_reset();
        @(posedge clk_i);
        #1;
        test_idle_yumi();
        test_known(FIPS_KEY, FIPS_R1, FIPS_R10, 0, "fips");
        test_known(128'h0, ZERO_R1, ZERO_R10, 0, "zero_key");
        test_random_stall();
        test_intrusion();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
